// File: rtl/ej32_pkg.sv
// Shared eJ32 types: stack op encoding and default data-stack geometry.
package ej32_pkg;

   typedef enum logic [1:0] {
      sNOP  = 2'd0,
      sPOP  = 2'd1,
      sPUSH = 2'd2,
      sMOVE = 2'd3
   } stack_op;

   localparam int SS_DEPTH = 64;
   localparam int SS_DW    = 32;

endpackage

// File: rtl/ej32_ss_ram.sv
// Data-stack register file: one synchronous write port, two asynchronous read ports.
module ss_ram #(
   parameter int DEPTH = 64,
   parameter int DW    = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] ra0,
   output logic [DW-1:0] rd0,
   input  logic [AW-1:0] ra1,
   output logic [DW-1:0] rd1
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   assign rd0 = mem[ra0];
   assign rd1 = mem[ra1];

endmodule

// File: rtl/ej32_ss.sv
// eJ32 data-stack slave: circular stack with depth tracking, sticky flags and a pick port.
module ej32_ss
   import ej32_pkg::*;
#(
   parameter int DEPTH = SS_DEPTH,
   parameter int DW    = SS_DW,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  stack_op       op,
   input  logic [DW-1:0] vi,
   output logic [DW-1:0] s,
   input  logic [AW-1:0] pidx,
   output logic [DW-1:0] pv,
   output logic [AW:0]   depth,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          udf,
   input  logic          clr
);

   localparam logic [AW:0] DFULL = (AW+1)'(DEPTH);

   logic [AW-1:0] sp, sp_n, sp_inc, sp_dec, wa;
   logic [AW:0]   depth_n;
   logic [DW-1:0] s_n, rd_pop;
   logic          ovf_n, udf_n, we;

   assign sp_inc = sp + 1'b1;
   assign sp_dec = sp - 1'b1;
   assign full   = (depth == DFULL);
   assign empty  = (depth == '0);

   ss_ram #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .AW    (AW)
   ) u_ram (
      .clk (clk),
      .we  (we),
      .wa  (wa),
      .wd  (vi),
      .ra0 (sp_dec),
      .rd0 (rd_pop),
      .ra1 (sp - pidx),
      .rd1 (pv)
   );

   // flag set takes priority over clr because the set assignments come last
   always_comb begin
      we      = 1'b0;
      wa      = sp;
      sp_n    = sp;
      depth_n = depth;
      s_n     = s;
      ovf_n   = ovf & ~clr;
      udf_n   = udf & ~clr;
      case (op)
         sPUSH: begin
            we   = rst;
            wa   = sp_inc;
            sp_n = sp_inc;
            s_n  = vi;
            if (full) ovf_n = 1'b1;
            else      depth_n = depth + 1'b1;
         end
         sPOP: begin
            sp_n = sp_dec;
            s_n  = rd_pop;
            if (empty) udf_n = 1'b1;
            else       depth_n = depth - 1'b1;
         end
         sMOVE: begin
            we  = rst;
            s_n = vi;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp    <= '0;
         depth <= '0;
         s     <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         sp    <= sp_n;
         depth <= depth_n;
         s     <= s_n;
         ovf   <= ovf_n;
         udf   <= udf_n;
      end
   end

endmodule

// File: tb/tb_ej32_ss.sv
// Scoreboard bench for ej32_ss: stimulus queues expectations, a monitor checks each cycle.
module tb_ej32_ss;
   import ej32_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   stack_op     op  = sNOP;
   logic [31:0] vi  = '0;
   logic [31:0] s, pv;
   logic [5:0]  pidx = '0;
   logic [6:0]  depth;
   logic        full, empty, ovf, udf;
   logic        clr = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ej32_ss #(.DEPTH(64), .DW(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .op    (op),
      .vi    (vi),
      .s     (s),
      .pidx  (pidx),
      .pv    (pv),
      .depth (depth),
      .full  (full),
      .empty (empty),
      .ovf   (ovf),
      .udf   (udf),
      .clr   (clr)
   );

   typedef struct {
      string       nm;
      bit          cs;
      logic [31:0] s;
      bit          cf;
      logic [6:0]  depth;
      bit          ovf, udf, full, empty;
      bit          cp;
      logic [31:0] pv;
   } exp_t;

   exp_t sbq[$];

   function automatic exp_t mk(string nm, bit cs, logic [31:0] es, logic [6:0] d, bit eo, bit eu);
      exp_t e;
      e.nm = nm; e.cs = cs; e.s = es; e.cf = 1'b1; e.depth = d;
      e.ovf = eo; e.udf = eu; e.full = (d == 7'd64); e.empty = (d == 7'd0);
      e.cp = 1'b0; e.pv = '0;
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // monitor: every negedge, compare post-edge outputs with the oldest expectation
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         if (e.cs) chk({e.nm, ".s"}, s, e.s);
         if (e.cf) begin
            chk({e.nm, ".depth"}, 32'(depth), 32'(e.depth));
            chk({e.nm, ".ovf"},   32'(ovf),   32'(e.ovf));
            chk({e.nm, ".udf"},   32'(udf),   32'(e.udf));
            chk({e.nm, ".full"},  32'(full),  32'(e.full));
            chk({e.nm, ".empty"}, 32'(empty), 32'(e.empty));
         end
         if (e.cp) chk({e.nm, ".pv"}, pv, e.pv);
      end
   end

   task automatic step(stack_op o, logic [31:0] v, bit c, logic [5:0] pi, exp_t e);
      @(negedge clk); #1;
      op = o; vi = v; clr = c; pidx = pi;
      @(posedge clk); #1;
      sbq.push_back(e);
   endtask

   // assert reset in the middle of a push, release with NOP
   task automatic do_reset();
      @(negedge clk); #1;
      op = sPUSH; vi = 32'h55; clr = 1'b0; pidx = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      op = sNOP;
      rst = 1'b1;
      @(posedge clk); #1;
      sbq.push_back(mk("reset", 1'b1, 32'h0, 7'd0, 1'b0, 1'b0));
   endtask

   logic [31:0] mq[$];
   bit          movf, mudf, sknown;
   logic [31:0] ms;

   initial begin
      exp_t e;
      stack_op o;
      logic [31:0] v;

      do_reset();

      // push 3, pop 2
      step(sPUSH, 32'h11, 0, 0, mk("t2.push1", 1, 32'h11, 7'd1, 0, 0));
      step(sPUSH, 32'h22, 0, 0, mk("t2.push2", 1, 32'h22, 7'd2, 0, 0));
      step(sPUSH, 32'h33, 0, 0, mk("t2.push3", 1, 32'h33, 7'd3, 0, 0));
      step(sPOP,  32'h0,  0, 0, mk("t2.pop1",  1, 32'h22, 7'd2, 0, 0));
      step(sPOP,  32'h0,  0, 0, mk("t2.pop2",  1, 32'h11, 7'd1, 0, 0));

      // fill, overflow, then drain
      do_reset();
      for (int i = 1; i <= 64; i++)
         step(sPUSH, 32'(i), 0, 0, mk("t3.fill", 1, 32'(i), 7'(i), 0, 0));
      step(sPUSH, 32'h65, 0, 0, mk("t3.ovfpush", 1, 32'h65, 7'd64, 1, 0));
      for (int j = 1; j <= 63; j++)
         step(sPOP, 32'h0, 0, 0, mk("t3.drain", 1, 32'(65 - j), 7'(64 - j), 1, 0));
      step(sPOP, 32'h0, 0, 0, mk("t3.last", 0, 32'h0, 7'd0, 1, 0));

      // underflow and clear
      do_reset();
      step(sPOP, 32'h0, 0, 0, mk("t4.udf",      0, 32'h0, 7'd0, 0, 1));
      step(sNOP, 32'h0, 1, 0, mk("t4.clr",      0, 32'h0, 7'd0, 0, 0));
      step(sPOP, 32'h0, 1, 0, mk("t4.setwins",  0, 32'h0, 7'd0, 0, 1));

      // move replaces the top
      do_reset();
      step(sPUSH, 32'hA, 0, 0, mk("t5.pushA", 1, 32'hA, 7'd1, 0, 0));
      step(sPUSH, 32'hB, 0, 0, mk("t5.pushB", 1, 32'hB, 7'd2, 0, 0));
      step(sMOVE, 32'hC, 0, 0, mk("t5.move",  1, 32'hC, 7'd2, 0, 0));
      step(sPOP,  32'h0, 0, 0, mk("t5.pop",   1, 32'hA, 7'd1, 0, 0));

      // pick port
      do_reset();
      for (int i = 1; i <= 8; i++)
         step(sPUSH, 32'(i), 0, 0, mk("t6.push", 1, 32'(i), 7'(i), 0, 0));
      for (int i = 0; i < 8; i++) begin
         e = mk("t6.pick", 1, 32'h8, 7'd8, 0, 0);
         e.cp = 1'b1;
         e.pv = 32'(8 - i);
         step(sNOP, 32'h0, 0, 6'(i), e);
      end

      // random ops against a queue model
      do_reset();
      mq.delete();
      movf = 0; mudf = 0; sknown = 1; ms = '0;
      for (int n = 0; n < 1000; n++) begin
         o = stack_op'($urandom_range(0, 3));
         v = $urandom;
         case (o)
            sPUSH: begin
               if (mq.size() == 64) begin
                  void'(mq.pop_front());
                  movf = 1;
               end
               mq.push_back(v);
               ms = v; sknown = 1;
            end
            sPOP: begin
               if (mq.size() == 0) mudf = 1;
               else void'(mq.pop_back());
               if (mq.size() > 0) begin
                  ms = mq[$]; sknown = 1;
               end else sknown = 0;
            end
            sMOVE: begin
               if (mq.size() > 0) mq[$] = v;
               ms = v; sknown = 1;
            end
            default: ;
         endcase
         step(o, v, 0, 0, mk("rand", sknown, ms, 7'(mq.size()), movf, mudf));
      end

      for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
      #2;
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
